// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter redirect controller:
// default widths, reset PC, FSM state type and the offset sign-extension helper.
package pc_pkg;

  localparam int          PC_W_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSN_BYTES       = 4;

  // RUN: normal fetch; FLUSH: squashing instructions fetched behind a taken branch.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Sign-extend a 16-bit branch word offset to 32 bits.
  function automatic logic [31:0] sext16_to_32(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_history.sv
// pc_history_shift: shift register of PC+4 values, one entry per pipeline
// stage between fetch and branch resolution. Holds while shift_en is low.
module pc_history_shift #(
  parameter int             W         = 32,
  parameter int             DEPTH     = 2,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [W-1:0] tail
);

  logic [DEPTH-1:0][W-1:0] hist_d;
  logic [DEPTH-1:0][W-1:0] hist_q;

  // Next history: newest value enters entry 0, older entries move one slot down.
  always_comb begin
    hist_d = hist_q;
    if (shift_en) begin
      hist_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        hist_d[i] = hist_q[i-1];
      end
    end
  end

  // History register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= {DEPTH{RESET_VAL}};
    end else begin
      hist_q <= hist_d;
    end
  end

  assign head = hist_q[0];
  assign tail = hist_q[DEPTH-1];

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: owns the program counter, applies taken-branch and jump
// redirects, and drives the registered flush/redirect controls.
// Optional build macro PC_REDIRECT_DELAY_SLOT_EN: the instruction right after a
// branch or jump executes (delay slot), so a branch flushes one cycle less and
// a jump flushes nothing.
// Handshake: there is none; branch_taken/jump are single-cycle qualifiers
// sampled at each rising edge, and stall simply freezes PC/history/counter.
module pc_redirect_ctrl
  import pc_pkg::*;
#(
  parameter int              PC_W          = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC      = PC_W'(RESET_PC_DEFAULT),
  parameter int              RESOLVE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [15:0]     branch_offset,
  input  logic            jump,
  input  logic [25:0]     jump_index,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            flush,
  output logic            redirect
);

`ifdef PC_REDIRECT_DELAY_SLOT_EN
  localparam int   BR_FLUSH_LEN = RESOLVE_DEPTH - 1;
  localparam logic JUMP_FLUSH   = 1'b0;
`else
  localparam int   BR_FLUSH_LEN = RESOLVE_DEPTH;
  localparam logic JUMP_FLUSH   = 1'b1;
`endif
  // The counter counts flush cycles still to go after the current one.
  localparam logic [1:0] CNT_INIT = 2'(BR_FLUSH_LEN - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            flush_q, flush_d;
  logic            redirect_q, redirect_d;
  logic            jump_flush;
  logic            hist_shift;
  logic [PC_W-1:0] hist_head;
  logic [PC_W-1:0] hist_tail;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jump_target;
  logic            unused_hist_head_lo;

  assign pc_plus4    = pc_q + PC_W'(INSN_BYTES);
  assign br_target   = hist_tail + (PC_W'($signed(sext16_to_32(branch_offset))) << 2);
  assign jump_target = {hist_head[PC_W-1:28], jump_index, 2'b00};
  assign unused_hist_head_lo = ^hist_head[27:0];

  pc_history_shift #(
    .W         (PC_W),
    .DEPTH     (RESOLVE_DEPTH),
    .RESET_VAL (RESET_PC + PC_W'(INSN_BYTES))
  ) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (hist_shift),
    .din      (pc_plus4),
    .head     (hist_head),
    .tail     (hist_tail)
  );

  // Next-state, next-PC and control outputs; branch beats jump beats stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    redirect_d = 1'b0;
    jump_flush = 1'b0;
    hist_shift = 1'b0;
    case (state_q)
      RUN: begin
        hist_shift = !stall;
        if (branch_taken) begin
          pc_d       = br_target;
          redirect_d = 1'b1;
          state_d    = FLUSH;
          cnt_d      = CNT_INIT;
        end else if (jump) begin
          pc_d       = jump_target;
          redirect_d = 1'b1;
          jump_flush = JUMP_FLUSH;
        end else if (!stall) begin
          pc_d = pc_plus4;
        end
      end
      FLUSH: begin
        // Branch/jump inputs here belong to squashed instructions.
        if (!stall) begin
          hist_shift = 1'b1;
          pc_d       = pc_plus4;
          if (cnt_q == 2'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      default: state_d = RUN;
    endcase
    flush_d = (state_d == FLUSH) || jump_flush;
  end

  // State, PC and registered controls; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      cnt_q      <= 2'd0;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc       = pc_q;
  assign flush    = flush_q;
  assign redirect = redirect_q;

endmodule
